// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM ramp generator.
package pwm_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    RAMP
  } pwm_state_t;

endpackage

// File: rtl/duty_stepper.sv
// Combinational next-duty calculation: one step toward target per tc, or a
// direct jump when not ramping. o_reached flags that the target is reached.
module duty_stepper #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_target,
  input  logic             i_ramp,
  input  logic             i_tc,
  output logic [WIDTH-1:0] o_next,
  output logic             o_reached
);

  always_comb begin
    o_next    = i_cur;
    o_reached = 1'b0;
    if (i_tc) begin
      if (!i_ramp)
        o_next = i_target;
      else if (i_cur < i_target)
        o_next = i_cur + 1'b1;
      else if (i_cur > i_target)
        o_next = i_cur - 1'b1;
      // Covers the equal-target case too: no step, but still completes.
      o_reached = (o_next == i_target);
    end
  end

endmodule

// File: rtl/pwm_ramp_gen.sv
// PWM generator driven by an external free-running counter. New duty values
// arrive by valid/ready and are applied at period boundaries (tc), in one step or ramped.
module pwm_ramp_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DUTY_RST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic             tc,
  input  logic [WIDTH-1:0] duty_req,
  input  logic             ramp_req,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty_cur,
  output logic             busy,
  output logic             upd_done
);

  localparam logic [WIDTH-1:0] L_DUTY_RST = WIDTH'(DUTY_RST);

  pwm_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_target, w_target_nxt;
  logic [WIDTH-1:0] r_duty, w_duty_nxt;
  logic             r_pwm;
  logic             r_done, w_done_nxt;

  logic [WIDTH-1:0] w_step;
  logic             w_reached;
  logic             w_step_tc;

  // tc in IDLE (including the transfer edge) is never acted on.
  assign w_step_tc = tc & (r_state != IDLE);

  duty_stepper #(.WIDTH(WIDTH)) u_stepper (
    .i_cur     (r_duty),
    .i_target  (r_target),
    .i_ramp    (r_state == RAMP),
    .i_tc      (w_step_tc),
    .o_next    (w_step),
    .o_reached (w_reached)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_duty_nxt   = r_duty;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (duty_valid) begin
          w_target_nxt = duty_req;
          w_state_nxt  = ramp_req ? RAMP : PEND;
        end
      end
      PEND, RAMP: begin
        w_duty_nxt = w_step;
        if (w_reached) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_target <= L_DUTY_RST;
      r_duty   <= L_DUTY_RST;
      r_pwm    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_duty   <= w_duty_nxt;
      // Pre-update duty; cnt == max always compares 0 so tc changes land cleanly.
      r_pwm    <= (cnt < r_duty);
      r_done   <= w_done_nxt;
    end
  end

  assign duty_ready = (r_state == IDLE);
  assign busy       = ~duty_ready;
  assign pwm_out    = r_pwm;
  assign duty_cur   = r_duty;
  assign upd_done   = r_done;

endmodule

// File: tb/tb_pwm_ramp_gen.sv
// Bench for pwm_ramp_gen: directed scenarios plus randomized traffic checked
// against a behavioural model of pending requests and per-period duty steps.
module tb_pwm_ramp_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic       tc = 1'b0;
  logic [3:0] duty_req = 4'd0;
  logic       ramp_req = 1'b0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, pwm_out, busy, upd_done;
  logic [3:0] duty_cur;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: one outstanding request (m_pend), its mode and target, active duty.
  bit         m_pend = 0, m_ramp = 0, m_pwm = 0, m_done = 0, m_acc = 0, e_tc = 0;
  logic [3:0] m_duty = 4'd0, m_target = 4'd0;

  always #5 clk = ~clk;

  pwm_ramp_gen #(.WIDTH(4), .DUTY_RST(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt        (cnt),
    .tc         (tc),
    .duty_req   (duty_req),
    .ramp_req   (ramp_req),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .duty_cur   (duty_cur),
    .busy       (busy),
    .upd_done   (upd_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Advance one clock: predict the edge from current inputs, then step the counter.
  task automatic tick();
    m_acc = 0;
    e_tc  = tc;
    if (!reset) begin
      m_pend = 0; m_duty = 4'd0; m_target = 4'd0; m_pwm = 0; m_done = 0;
    end else begin
      m_pwm  = (cnt < m_duty);
      m_done = 0;
      if (m_pend) begin
        if (tc) begin
          if (!m_ramp)                m_duty = m_target;
          else if (m_duty < m_target) m_duty = m_duty + 4'd1;
          else if (m_duty > m_target) m_duty = m_duty - 4'd1;
          if (m_duty == m_target) begin
            m_pend = 0; m_done = 1;
          end
        end
      end else if (duty_valid) begin
        m_pend = 1; m_ramp = ramp_req; m_target = duty_req; m_acc = 1;
      end
    end
    @(posedge clk);
    #1;
    cnt = cnt + 4'd1;
    tc  = (cnt == 4'd15);
  endtask

  task automatic wait_cnt(input logic [3:0] v);
    for (int i = 0; i < 20 && cnt != v; i++) tick();
  endtask

  task automatic apply_req(input logic [3:0] d, input bit r);
    bit ok = 0;
    duty_req = d; ramp_req = r; duty_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = m_acc;
    end
    duty_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL accept_timeout: got 0 want 1"); end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy !== 1'b0 && i < 300) begin tick(); i++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_timeout: got %0b want 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_cmp += 5;
    if (duty_cur !== 4'd0)  begin n_fail++; $display("FAIL rst_duty: got %0d want 0", duty_cur); end
    if (pwm_out !== 1'b0)   begin n_fail++; $display("FAIL rst_pwm: got %0b want 0", pwm_out); end
    if (duty_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", duty_ready); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    if (upd_done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %0b want 0", upd_done); end
    reset = 1'b1;
  endtask

  task automatic test_idle_run();
    int hi = 0, bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hi += int'(pwm_out);
      if (duty_ready !== 1'b1 || busy !== 1'b0 || upd_done !== 1'b0 || duty_cur !== 4'd0) bad++;
    end
    n_cmp += 2;
    if (hi != 0)  begin n_fail++; $display("FAIL idle_pwm: got %0d highs want 0", hi); end
    if (bad != 0) begin n_fail++; $display("FAIL idle_status: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_step();
    logic [15:0] mask = '0;
    int nb = 0;
    wait_cnt(4'd3);
    duty_req = 4'd5; ramp_req = 1'b0; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    n_cmp += 2;
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL step_busy: got %0b want 1", busy); end
    if (duty_cur !== 4'd0) begin n_fail++; $display("FAIL step_early: got %0d want 0", duty_cur); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (e_tc) break;
      if (busy !== 1'b1 || upd_done !== 1'b0) nb++;
    end
    n_cmp += 4;
    if (nb != 0)           begin n_fail++; $display("FAIL step_wait: got %0d bad cycles want 0", nb); end
    if (duty_cur !== 4'd5) begin n_fail++; $display("FAIL step_duty: got %0d want 5", duty_cur); end
    if (upd_done !== 1'b1) begin n_fail++; $display("FAIL step_done: got %0b want 1", upd_done); end
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL step_idle: got %0b want 0", busy); end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++;
        if (upd_done !== 1'b0) begin n_fail++; $display("FAIL step_pulse: got %0b want 0", upd_done); end
      end
      mask[i] = pwm_out;
    end
    n_cmp++;
    if (mask !== 16'h001F) begin n_fail++; $display("FAIL step_pwm: got %h want 001f", mask); end
  endtask

  task automatic test_ramp();
    logic [15:0] seq = '0;
    int ntc = 0, ndone = 0, nrdy = 0, nstay = 0;
    apply_req(4'd2, 1'b0);
    wait_idle();
    apply_req(4'd6, 1'b1);
    // A competing request held during the ramp must be ignored.
    duty_req = 4'd0; ramp_req = 1'b0; duty_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (e_tc) begin seq = {seq[11:0], duty_cur}; ntc++; end
      if (upd_done === 1'b1) begin ndone++; break; end
      if (duty_ready !== 1'b0) nrdy++;
    end
    duty_valid = 1'b0;
    n_cmp += 4;
    if (seq !== 16'h3456) begin n_fail++; $display("FAIL ramp_seq: got %h want 3456", seq); end
    if (ntc != 4)   begin n_fail++; $display("FAIL ramp_tcs: got %0d want 4", ntc); end
    if (ndone != 1) begin n_fail++; $display("FAIL ramp_done: got %0d want 1", ndone); end
    if (nrdy != 0)  begin n_fail++; $display("FAIL ramp_ready: got %0d bad cycles want 0", nrdy); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (duty_cur !== 4'd6 || busy !== 1'b0 || upd_done !== 1'b0) nstay++;
    end
    n_cmp++;
    if (nstay != 0) begin n_fail++; $display("FAIL ramp_ignored: got %0d bad cycles want 0", nstay); end
  endtask

  task automatic test_tc_edge();
    int nb = 0;
    wait_cnt(4'd15);
    duty_req = 4'd9; ramp_req = 1'b0; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    n_cmp += 2;
    if (duty_cur !== 4'd6 || upd_done !== 1'b0) begin
      n_fail++; $display("FAIL tcedge_now: got %0d/%0b want 6/0", duty_cur, upd_done);
    end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL tcedge_busy: got %0b want 1", busy); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (duty_cur !== 4'd6 || upd_done !== 1'b0) nb++;
    end
    tick();
    n_cmp += 2;
    if (nb != 0) begin n_fail++; $display("FAIL tcedge_hold: got %0d bad cycles want 0", nb); end
    if (duty_cur !== 4'd9 || upd_done !== 1'b1) begin
      n_fail++; $display("FAIL tcedge_apply: got %0d/%0b want 9/1", duty_cur, upd_done);
    end
  endtask

  task automatic test_reset_mid();
    int ntc = 0, nb = 0;
    apply_req(4'd15, 1'b0);
    wait_idle();
    apply_req(4'd0, 1'b1);
    for (int i = 0; i < 100 && ntc < 3; i++) begin
      tick();
      if (e_tc) ntc++;
    end
    n_cmp++;
    if (duty_cur !== 4'd12) begin n_fail++; $display("FAIL mid_pre: got %0d want 12", duty_cur); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp += 3;
    if (duty_cur !== 4'd0) begin n_fail++; $display("FAIL mid_duty: got %0d want 0", duty_cur); end
    if (duty_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_state: got rdy %0b busy %0b want 1/0", duty_ready, busy);
    end
    if (pwm_out !== 1'b0 || upd_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_out: got pwm %0b done %0b want 0/0", pwm_out, upd_done);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (duty_cur !== 4'd0 || upd_done !== 1'b0 || pwm_out !== 1'b0) nb++;
    end
    n_cmp++;
    if (nb != 0) begin n_fail++; $display("FAIL mid_discard: got %0d bad cycles want 0", nb); end
  endtask

  task automatic test_equal();
    int nb = 0;
    apply_req(4'd7, 1'b0);
    wait_idle();
    apply_req(4'd7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (e_tc) break;
      if (upd_done !== 1'b0 || duty_cur !== 4'd7) nb++;
    end
    n_cmp += 2;
    if (nb != 0) begin n_fail++; $display("FAIL eq_wait: got %0d bad cycles want 0", nb); end
    if (upd_done !== 1'b1 || duty_cur !== 4'd7 || busy !== 1'b0) begin
      n_fail++; $display("FAIL eq_done: got %0b/%0d/%0b want 1/7/0", upd_done, duty_cur, busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_req   = 4'($urandom_range(0, 15));
      ramp_req   = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 49) == 0) tc = 1'b1;
      tick();
      n_cmp += 5;
      if (duty_cur !== m_duty)  begin n_fail++; $display("FAIL rnd_duty @%0d: got %0d want %0d", i, duty_cur, m_duty); end
      if (pwm_out !== m_pwm)    begin n_fail++; $display("FAIL rnd_pwm @%0d: got %0b want %0b", i, pwm_out, m_pwm); end
      if (upd_done !== m_done)  begin n_fail++; $display("FAIL rnd_done @%0d: got %0b want %0b", i, upd_done, m_done); end
      if (busy !== m_pend)      begin n_fail++; $display("FAIL rnd_busy @%0d: got %0b want %0b", i, busy, m_pend); end
      if (duty_ready !== !m_pend) begin n_fail++; $display("FAIL rnd_ready @%0d: got %0b want %0b", i, duty_ready, !m_pend); end
    end
    duty_valid = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idle_run();
    test_step();
    test_ramp();
    test_tc_edge();
    test_reset_mid();
    test_equal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
